shift_reg_piso: RTL and testbench

Parallel-in, serial-out shift register with a load handshake and bit counter. It is the transmit end of the serial link whose receive end is `shift_reg_sipo`. It accepts a WIDTH-bit word and drives it onto a single serial line, one bit per `clk`, MSB first by default. With that default, a `shift_reg_sipo` on the same clock reassembles the original word. Back-to-back words stream with no idle cycle between them.

---
 rtl/shift_reg_piso.sv | 56 +++++
 tb/tb_shift_reg_piso.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_piso.sv
// shift_reg_piso: parallel-in serial-out shifter with load handshake, streams words back-to-back
module shift_reg_piso #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             q,
  output logic             q_valid,
  output logic             last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             xfer;
  assign last       = state == SHIFT && cnt == CW'(WIDTH - 1);
  assign load_ready = !reset && (state == IDLE || last);
  assign xfer       = load_valid && load_ready;
  assign q_valid    = state == SHIFT;
  assign busy       = q_valid;
  assign q          = LSB_FIRST ? sreg[0] : sreg[WIDTH-1];
  // a reload in the last cycle wins over returning to idle, so words stream gap-free
  always_comb begin
    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    if (xfer) begin
      state_n = SHIFT;
      sreg_n  = din;
      cnt_n   = '0;
    end else if (last) begin
      state_n = IDLE;
      sreg_n  = '0;
    end else if (state == SHIFT) begin
      sreg_n = LSB_FIRST ? sreg >> 1 : sreg << 1;
      cnt_n  = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end
endmodule

// File: tb/tb_shift_reg_piso.sv
// tb_shift_reg_piso: directed checks of both bit orders, back-pressure, abort and loopback
module tb_shift_reg_piso;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] din = '0, din1 = '0;
  logic       lv = 1'b0, lv1 = 1'b0;
  logic       ready, q, qv, last, busy;
  logic       ready1, q1, qv1, last1, busy1;
  logic [3:0] rx = '0;
  int         checks = 0, errors = 0;

  shift_reg_piso #(.WIDTH(4), .LSB_FIRST(0)) u0 (
    .clk(clk), .reset(reset), .din(din), .load_valid(lv), .load_ready(ready),
    .q(q), .q_valid(qv), .last(last), .busy(busy));
  shift_reg_piso #(.WIDTH(4), .LSB_FIRST(1)) u1 (
    .clk(clk), .reset(reset), .din(din1), .load_valid(lv1), .load_ready(ready1),
    .q(q1), .q_valid(qv1), .last(last1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) rx <= {rx[2:0], q};

  task automatic test_reset;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00000) begin
      errors++; $display("FAIL reset_hold got %b want 00000", {q, qv, last, busy, ready});
    end
    checks++;
    if ({q1, qv1, last1, busy1, ready1} !== 5'b00000) begin
      errors++; $display("FAIL reset_hold_lsb got %b want 00000", {q1, qv1, last1, busy1, ready1});
    end
    @(posedge clk); #3 reset = 1'b0; #1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({q, qv, last, busy, ready} !== 5'b00001) begin
        errors++; $display("FAIL idle_%0d got %b want 00001", i, {q, qv, last, busy, ready});
      end
      @(posedge clk); #1;
    end
    #3 reset = 1'b1; #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00000) begin
      errors++; $display("FAIL async_reset_idle got %b want 00000", {q, qv, last, busy, ready});
    end
    @(posedge clk); #2 reset = 1'b0; #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_release got %b want 00001", {q, qv, last, busy, ready});
    end
  endtask

  task automatic test_single;
    logic [3:0] w = 4'b1010;
    logic [4:0] e;
    @(posedge clk); #1 lv = 1'b1; din = w;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) lv = 1'b0;
      e = {w[3-i], 1'b1, i == 3, 1'b1, i == 3};
      checks++;
      if ({q, qv, last, busy, ready} !== e) begin
        errors++; $display("FAIL single_bit%0d got %b want %b", i, {q, qv, last, busy, ready}, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00001) begin
      errors++; $display("FAIL single_after got %b want 00001", {q, qv, last, busy, ready});
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] s = 8'b1010_0110;
    logic [4:0] e;
    @(posedge clk); #1 lv = 1'b1; din = 4'b1010;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 0) din = 4'b0110;
      if (i == 4) lv = 1'b0;
      e = {s[7-i], 1'b1, i % 4 == 3, 1'b1, i % 4 == 3};
      checks++;
      if ({q, qv, last, busy, ready} !== e) begin
        errors++; $display("FAIL b2b_bit%0d got %b want %b", i, {q, qv, last, busy, ready}, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00001) begin
      errors++; $display("FAIL b2b_after got %b want 00001", {q, qv, last, busy, ready});
    end
  endtask

  task automatic test_backpressure;
    logic [3:0] vals [13] = '{4'b1100, 4'b1111, 4'b0000, 4'b0111, 4'b0011, 4'b1111, 4'b1110,
                              4'b0101, 4'b1001, 4'b0000, 4'b1111, 4'b0110, 4'b0000};
    logic [11:0] s = 12'b1100_0011_1001;
    logic [4:0]  e;
    @(posedge clk); #1 lv = 1'b1; din = vals[0];
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1 din = vals[i+1];
      e = {s[11-i], 1'b1, i % 4 == 3, 1'b1, i % 4 == 3};
      checks++;
      if ({q, qv, last, busy, ready} !== e) begin
        errors++; $display("FAIL bp_bit%0d got %b want %b", i, {q, qv, last, busy, ready}, e);
      end
      if (i == 11) lv = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00001) begin
      errors++; $display("FAIL bp_after got %b want 00001", {q, qv, last, busy, ready});
    end
  endtask

  task automatic test_lsb_first;
    logic [3:0] s = 4'b1000;
    logic [4:0] e;
    @(posedge clk); #1 lv1 = 1'b1; din1 = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) lv1 = 1'b0;
      e = {s[3-i], 1'b1, i == 3, 1'b1, i == 3};
      checks++;
      if ({q1, qv1, last1, busy1, ready1} !== e) begin
        errors++; $display("FAIL lsb_bit%0d got %b want %b", i, {q1, qv1, last1, busy1, ready1}, e);
      end
    end
    @(posedge clk); #1;
    checks++;
    if ({q1, qv1, last1, busy1, ready1} !== 5'b00001) begin
      errors++; $display("FAIL lsb_after got %b want 00001", {q1, qv1, last1, busy1, ready1});
    end
  endtask

  task automatic test_abort_loopback;
    @(posedge clk); #1 lv = 1'b1; din = 4'b1111;
    @(posedge clk); #1 lv = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b11010) begin
      errors++; $display("FAIL abort_bit2 got %b want 11010", {q, qv, last, busy, ready});
    end
    #3 reset = 1'b1; #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00000) begin
      errors++; $display("FAIL abort_async got %b want 00000", {q, qv, last, busy, ready});
    end
    @(posedge clk); #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00000) begin
      errors++; $display("FAIL abort_hold got %b want 00000", {q, qv, last, busy, ready});
    end
    #2 reset = 1'b0; #1;
    checks++;
    if ({q, qv, last, busy, ready} !== 5'b00001) begin
      errors++; $display("FAIL abort_release got %b want 00001", {q, qv, last, busy, ready});
    end
    lv = 1'b1; din = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) lv = 1'b0;
    end
    checks++;
    if (last !== 1'b1) begin
      errors++; $display("FAIL loop_last got %b want 1", last);
    end
    @(posedge clk); #1;
    checks++;
    if (rx !== 4'b1001) begin
      errors++; $display("FAIL loopback got %b want 1001", rx);
    end
  endtask

  initial begin
    #2;
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_lsb_first;
    test_abort_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
